// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, field widths and fill-FSM state encoding
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int XMAX_HI = 320;
    localparam int YMAX_HI = 240;
    localparam int XMAX_LO = 160;
    localparam int YMAX_LO = 120;

    function automatic int xmax_of(input bit lowres);
        return lowres ? XMAX_LO : XMAX_HI;
    endfunction

    function automatic int ymax_of(input bit lowres);
        return lowres ? YMAX_LO : YMAX_HI;
    endfunction

    function automatic int xw_of(input bit lowres);
        return lowres ? 8 : 9;
    endfunction

    function automatic int yw_of(input bit lowres);
        return lowres ? 7 : 8;
    endfunction

    function automatic int cw_of(input bit mono, input int bits_per_channel);
        return mono ? 1 : 3 * bits_per_channel;
    endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// rtl/vga_raster_counter.sv - nested x/y raster counter with origin load and last-pixel flag
module vga_raster_counter #(
    parameter int XW = 9,
    parameter int YW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [XW-1:0] i_x0,
    input  logic [YW-1:0] i_y0,
    input  logic [XW-1:0] i_x_last,
    input  logic [YW-1:0] i_y_last,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last
);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] r_x0;
    logic [XW-1:0] r_x_last;
    logic [YW-1:0] r_y_last;
    logic          w_x_wrap;

    assign w_x_wrap = (r_x == r_x_last);
    assign o_last   = w_x_wrap && (r_y == r_y_last);
    assign o_x      = r_x;
    assign o_y      = r_y;

    // Load origin and inclusive bounds, then walk the rectangle in raster order; hold otherwise
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_x0     <= '0;
            r_x_last <= '0;
            r_y_last <= '0;
        end else if (i_load) begin
            r_x      <= i_x0;
            r_y      <= i_y0;
            r_x0     <= i_x0;
            r_x_last <= i_x_last;
            r_y_last <= i_y_last;
        end else if (i_step) begin
            if (w_x_wrap) begin
                r_x <= r_x0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_rect_filler.sv
// rtl/vga_rect_filler.sv - turns a rectangle-fill or screen-clear command into one pixel write per clock
module vga_rect_filler
    import vga_pkg::*;
#(
    parameter string RESOLUTION              = "320x240",
    parameter int    BITS_PER_COLOUR_CHANNEL = 2,
    parameter string MONOCHROME              = "FALSE",
    localparam int   XW = xw_of(RESOLUTION == "160x120"),
    localparam int   YW = yw_of(RESOLUTION == "160x120"),
    localparam int   CW = cw_of(MONOCHROME == "TRUE", BITS_PER_COLOUR_CHANNEL)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          clear_screen,
    input  logic [XW-1:0] cmd_x0,
    input  logic [YW-1:0] cmd_y0,
    input  logic [XW:0]   cmd_width,
    input  logic [YW:0]   cmd_height,
    input  logic [CW-1:0] cmd_colour,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam bit LOWRES = (RESOLUTION == "160x120");
    localparam int XMAX   = xmax_of(LOWRES);
    localparam int YMAX   = ymax_of(LOWRES);

    // Two spare bits so origin + size never wraps before clipping
    localparam logic [XW+1:0] XMAX_E = (XW+2)'(XMAX);
    localparam logic [YW+1:0] YMAX_E = (YW+2)'(YMAX);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_colour;

    logic [XW-1:0] w_x0;
    logic [YW-1:0] w_y0;
    logic [XW:0]   w_w;
    logic [YW:0]   w_h;
    logic [XW+1:0] w_sum_x;
    logic [YW+1:0] w_sum_y;
    logic [XW+1:0] w_x_end;
    logic [YW+1:0] w_y_end;
    logic [XW-1:0] w_x_last;
    logic [YW-1:0] w_y_last;
    logic          w_empty;
    logic          w_cmd;
    logic          w_load;
    logic          w_step;
    logic          w_last;

    // A clear is just a full-screen rectangle; it takes priority over start
    assign w_cmd = start || clear_screen;
    assign w_x0  = clear_screen ? '0 : cmd_x0;
    assign w_y0  = clear_screen ? '0 : cmd_y0;
    assign w_w   = clear_screen ? (XW+1)'(XMAX) : cmd_width;
    assign w_h   = clear_screen ? (YW+1)'(YMAX) : cmd_height;

    assign w_sum_x  = {2'b00, w_x0} + {1'b0, w_w};
    assign w_sum_y  = {2'b00, w_y0} + {1'b0, w_h};
    assign w_x_end  = (w_sum_x > XMAX_E) ? XMAX_E : w_sum_x;
    assign w_y_end  = (w_sum_y > YMAX_E) ? YMAX_E : w_sum_y;
    assign w_x_last = XW'(w_x_end - 1'b1);
    assign w_y_last = YW'(w_y_end - 1'b1);

    assign w_empty = (w_w == '0) || (w_h == '0) ||
                     ({2'b00, w_x0} >= XMAX_E) || ({2'b00, w_y0} >= YMAX_E);

    vga_raster_counter #(
        .XW (XW),
        .YW (YW)
    ) u_raster (
        .i_clk    (clock),
        .i_reset  (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_x0     (w_x0),
        .i_y0     (w_y0),
        .i_x_last (w_x_last),
        .i_y_last (w_y_last),
        .o_x      (x),
        .o_y      (y),
        .o_last   (w_last)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and counter control: commands only count in IDLE, empty ones skip DRAW
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd) begin
                    if (w_empty) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_DRAW;
                        w_load       = 1'b1;
                    end
                end
            end
            ST_DRAW: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Colour is captured together with the origin so it stays put while plot is low
    always_ff @(posedge clock) begin
        if (reset) begin
            r_colour <= '0;
        end else if (w_load) begin
            r_colour <= cmd_colour;
        end
    end

    assign colour = r_colour;
    assign plot   = (r_state == ST_DRAW);
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_vga_rect_filler.sv
// tb/tb_vga_rect_filler.sv - self-checking bench for vga_rect_filler (320x240 colour and 160x120 mono)
module tb_vga_rect_filler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       h_start, h_clear;
    logic [8:0] h_x0;
    logic [7:0] h_y0;
    logic [9:0] h_w;
    logic [8:0] h_h;
    logic [5:0] h_col;
    logic [8:0] h_x;
    logic [7:0] h_y;
    logic [5:0] h_colour;
    logic       h_plot, h_busy, h_done;

    logic       l_start, l_clear;
    logic [7:0] l_x0;
    logic [6:0] l_y0;
    logic [8:0] l_w;
    logic [7:0] l_h;
    logic [0:0] l_col;
    logic [7:0] l_x;
    logic [6:0] l_y;
    logic [0:0] l_colour;
    logic       l_plot, l_busy, l_done;

    vga_rect_filler u_hi (
        .clock        (clk),
        .reset        (reset),
        .start        (h_start),
        .clear_screen (h_clear),
        .cmd_x0       (h_x0),
        .cmd_y0       (h_y0),
        .cmd_width    (h_w),
        .cmd_height   (h_h),
        .cmd_colour   (h_col),
        .x            (h_x),
        .y            (h_y),
        .colour       (h_colour),
        .plot         (h_plot),
        .busy         (h_busy),
        .done         (h_done)
    );

    vga_rect_filler #(
        .RESOLUTION ("160x120"),
        .MONOCHROME ("TRUE")
    ) u_lo (
        .clock        (clk),
        .reset        (reset),
        .start        (l_start),
        .clear_screen (l_clear),
        .cmd_x0       (l_x0),
        .cmd_y0       (l_y0),
        .cmd_width    (l_w),
        .cmd_height   (l_h),
        .cmd_colour   (l_col),
        .x            (l_x),
        .y            (l_y),
        .colour       (l_colour),
        .plot         (l_plot),
        .busy         (l_busy),
        .done         (l_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t q_hi[$];
    pix_t q_lo[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected writes: every on-screen pixel of the rectangle, rows top to bottom, left to right
    task automatic model(input bit lo, input int x0, input int y0, input int w, input int h,
                         input int c, output int n);
        int xmax = lo ? 160 : 320;
        int ymax = lo ? 120 : 240;
        int xe   = (x0 + w < xmax) ? x0 + w : xmax;
        int ye   = (y0 + h < ymax) ? y0 + h : ymax;
        pix_t p;
        n = 0;
        if (w == 0 || h == 0 || x0 >= xmax || y0 >= ymax) return;
        for (int yy = y0; yy < ye; yy++) begin
            for (int xx = x0; xx < xe; xx++) begin
                p.x = xx;
                p.y = yy;
                p.c = c;
                if (lo) q_lo.push_back(p);
                else    q_hi.push_back(p);
                n++;
            end
        end
    endtask

    // Every plot-high cycle must be the next expected pixel of the active command
    always @(negedge clk) begin
        pix_t e;
        if (h_plot === 1'b1) begin
            if (q_hi.size() == 0) begin
                check("hi_unexpected_write", 1, 0);
            end else begin
                e = q_hi.pop_front();
                n_tests++;
                if (h_x !== e.x[8:0] || h_y !== e.y[7:0] || h_colour !== e.c[5:0]) begin
                    n_fail++;
                    $display("FAIL hi_pixel: got (%0d,%0d,%0h) expected (%0d,%0d,%0h)",
                             h_x, h_y, h_colour, e.x, e.y, e.c);
                end
            end
        end
        if (l_plot === 1'b1) begin
            if (q_lo.size() == 0) begin
                check("lo_unexpected_write", 1, 0);
            end else begin
                e = q_lo.pop_front();
                n_tests++;
                if (l_x !== e.x[7:0] || l_y !== e.y[6:0] || l_colour !== e.c[0:0]) begin
                    n_fail++;
                    $display("FAIL lo_pixel: got (%0d,%0d,%0h) expected (%0d,%0d,%0h)",
                             l_x, l_y, l_colour, e.x, e.y, e.c);
                end
            end
        end
    end

    // Issue one command and check plot/done/busy timing over exactly n+2 cycles
    task automatic run(input bit lo, input bit clr, input bit st, input int x0, input int y0,
                       input int w, input int h, input int c, input int ping_at, input string tag,
                       output int n, output int fx, output int fy, output int lx, output int ly,
                       output int fc);
        int bad_plot = 0;
        int bad_done = 0;
        int bad_busy = 0;
        logic p, d, b;
        if (clr) model(lo, 0, 0, lo ? 160 : 320, lo ? 120 : 240, c, n);
        else     model(lo, x0, y0, w, h, c, n);
        fx = -1; fy = -1; lx = -1; ly = -1; fc = -1;
        @(negedge clk);
        if (lo) begin
            l_x0 = x0[7:0]; l_y0 = y0[6:0]; l_w = w[8:0]; l_h = h[7:0]; l_col = c[0:0];
            l_start = st; l_clear = clr;
        end else begin
            h_x0 = x0[8:0]; h_y0 = y0[7:0]; h_w = w[9:0]; h_h = h[8:0]; h_col = c[5:0];
            h_start = st; h_clear = clr;
        end
        @(posedge clk);
        for (int i = 0; i <= n + 1; i++) begin
            @(negedge clk);
            p = lo ? l_plot : h_plot;
            d = lo ? l_done : h_done;
            b = lo ? l_busy : h_busy;
            if (p !== (i < n)) bad_plot++;
            if (d !== (i == n)) bad_done++;
            if (b !== (i <= n)) bad_busy++;
            if (i == 0) begin
                fx = lo ? int'(l_x) : int'(h_x);
                fy = lo ? int'(l_y) : int'(h_y);
                fc = lo ? int'(l_colour) : int'(h_colour);
            end
            if (i == n - 1) begin
                lx = lo ? int'(l_x) : int'(h_x);
                ly = lo ? int'(l_y) : int'(h_y);
            end
            // Commands arriving mid-fill must be ignored, including changed command fields
            if (lo) begin
                l_start = (i == ping_at); l_clear = (i == ping_at);
                if (i == ping_at) begin l_x0 = 8'd3; l_col = ~c[0:0]; end
            end else begin
                h_start = (i == ping_at); h_clear = (i == ping_at);
                if (i == ping_at) begin h_x0 = 9'd5; h_y0 = 8'd7; h_col = ~c[5:0]; end
            end
        end
        check({tag, "_plot_window"}, bad_plot, 0);
        check({tag, "_done_pulse"}, bad_done, 0);
        check({tag, "_busy_window"}, bad_busy, 0);
        check({tag, "_writes_left"}, lo ? q_lo.size() : q_hi.size(), 0);
    endtask

    int n, fx, fy, lx, ly, fc;

    initial begin
        reset = 1'b1;
        h_start = 0; h_clear = 0; h_x0 = 0; h_y0 = 0; h_w = 0; h_h = 0; h_col = 0;
        l_start = 0; l_clear = 0; l_x0 = 0; l_y0 = 0; l_w = 0; l_h = 0; l_col = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi_x", h_x, 0);
        check("rst_hi_y", h_y, 0);
        check("rst_hi_colour", h_colour, 0);
        check("rst_hi_plot", h_plot, 0);
        check("rst_hi_busy", h_busy, 0);
        check("rst_hi_done", h_done, 0);
        check("rst_lo_plot", l_plot, 0);
        check("rst_lo_busy", l_busy, 0);
        reset = 1'b0;

        // Basic 3x2 rectangle, with a stray command mid-fill
        run(0, 0, 1, 10, 20, 3, 2, 'h2A, 2, "t1", n, fx, fy, lx, ly, fc);
        check("t1_count", n, 6);
        check("t1_first_x", fx, 10);
        check("t1_first_y", fy, 20);
        check("t1_colour", fc, 'h2A);
        check("t1_last_x", lx, 12);
        check("t1_last_y", ly, 21);

        // Clipped at the bottom-right corner
        run(0, 0, 1, 318, 239, 5, 4, 7, -1, "t2", n, fx, fy, lx, ly, fc);
        check("t2_count", n, 2);
        check("t2_first_x", fx, 318);
        check("t2_last_x", lx, 319);
        check("t2_last_y", ly, 239);

        // Empty commands: zero width, off-screen origin, zero height
        run(0, 0, 1, 10, 10, 0, 5, 3, -1, "t3a", n, fx, fy, lx, ly, fc);
        check("t3a_count", n, 0);
        run(0, 0, 1, 320, 0, 5, 5, 3, -1, "t3b", n, fx, fy, lx, ly, fc);
        check("t3b_count", n, 0);
        run(0, 0, 1, 0, 239, 4, 0, 3, -1, "t3c", n, fx, fy, lx, ly, fc);
        check("t3c_count", n, 0);

        // Clear together with start: clear wins, full screen once, stray command ignored
        run(0, 1, 1, 1, 1, 2, 2, 0, 500, "t4", n, fx, fy, lx, ly, fc);
        check("t4_count", n, 76800);
        check("t4_first_x", fx, 0);
        check("t4_first_y", fy, 0);
        check("t4_last_x", lx, 319);
        check("t4_last_y", ly, 239);

        // Reset during the third pixel of a 4x4 fill
        model(0, 50, 60, 4, 4, 5, n);
        @(negedge clk);
        h_x0 = 9'd50; h_y0 = 8'd60; h_w = 10'd4; h_h = 9'd4; h_col = 6'd5; h_start = 1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            h_start = 0;
            check("t5_pre_plot", h_plot, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_plot", h_plot, 0);
        check("t5_rst_busy", h_busy, 0);
        check("t5_rst_done", h_done, 0);
        q_hi.delete();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_done", h_done, 0);
        end
        run(0, 0, 1, 50, 60, 4, 4, 5, -1, "t5", n, fx, fy, lx, ly, fc);
        check("t5_count", n, 16);
        check("t5_last_x", lx, 53);
        check("t5_last_y", ly, 63);

        // Low-resolution monochrome: full-height column at the right edge
        run(1, 0, 1, 159, 0, 1, 120, 1, 40, "t6", n, fx, fy, lx, ly, fc);
        check("t6_count", n, 120);
        check("t6_first_x", fx, 159);
        check("t6_first_y", fy, 0);
        check("t6_colour", fc, 1);
        check("t6_last_x", lx, 159);
        check("t6_last_y", ly, 119);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
